// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared constants and operation encoding for pipe_adder
package pipe_adder_pkg;

  localparam int PIPE_ADDER_WIDTH  = 32;
  localparam int PIPE_ADDER_STAGES = 2;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/pipe_adder_chunk.sv
// rtl/pipe_adder_chunk.sv - one CW-bit slice of the carry-chunked adder
module pipe_adder_chunk
  import pipe_adder_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - STAGES-deep chunked add/sub pipeline, flags under PIPE_ADDER_FLAGS_EN
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = PIPE_ADDER_WIDTH,
  parameter int STAGES = PIPE_ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] adder_out,
  output logic             carry_out
`ifdef PIPE_ADDER_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  op_e  op;
  logic stall;

  // Per-stage inputs: stage 0 sees the ports, stage k sees rank k-1.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  logic [CW-1:0]    chunk_sum  [STAGES];
  logic             chunk_cout [STAGES];

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q,   sum_d;

`ifdef PIPE_ADDER_FLAGS_EN
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;
`endif

  assign op    = sub ? OP_SUB : OP_ADD;
  assign stall = valid_q[LAST] && !out_ready;

  // Subtraction enters as A + ~B with carry-in 1.
  assign a_in[0] = in1;
  assign b_in[0] = (op == OP_SUB) ? ~in2 : in2;
  assign s_in[0] = '0;
  assign c_in[0] = (op == OP_SUB);
  assign v_in[0] = in_valid;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign s_in[k] = sum_q[k-1];
    assign c_in[k] = carry_q[k-1];
    assign v_in[k] = valid_q[k-1];
  end

  if (STAGES > 1) begin : g_skew
    logic [STAGES-2:0][WIDTH-1:0] a_q, a_d, b_q, b_d;

    for (genvar k = 1; k < STAGES; k++) begin : g_tap
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
    end

    // Operand words move one rank per cycle alongside their partial sum
    always_comb begin
      a_d = '0;
      b_d = '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        a_d[k] = a_in[k];
        b_d[k] = b_in[k];
      end
    end

    // Skew ranks hold with the rest of the pipeline on a stall
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
      end else if (!stall) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_chunk #(.CW(CW)) u_chunk (
      .a    (a_in[k][k*CW +: CW]),
      .b    (b_in[k][k*CW +: CW]),
      .cin  (c_in[k]),
      .sum  (chunk_sum[k]),
      .cout (chunk_cout[k])
    );
  end

  // Each rank adds its own chunk and keeps the already finished lower chunks
  always_comb begin
    valid_d = '0;
    carry_d = '0;
    sum_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k]            = v_in[k];
      sum_d[k]              = s_in[k];
      sum_d[k][k*CW +: CW]  = chunk_sum[k];
      carry_d[k]            = chunk_cout[k];
    end
`ifdef PIPE_ADDER_FLAGS_EN
    zero_d = (sum_d[LAST] == '0);
    ovf_d  = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
             (sum_d[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
`endif
  end

  // All ranks advance together unless the output beat is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
`ifdef PIPE_ADDER_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else if (!stall) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
`ifdef PIPE_ADDER_FLAGS_EN
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign in_ready  = !stall;
  assign out_valid = valid_q[LAST];
  assign adder_out = sum_q[LAST];
  assign carry_out = carry_q[LAST];
`ifdef PIPE_ADDER_FLAGS_EN
  assign overflow  = ovf_q;
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder (STAGES 2, plus 16-bit STAGES 1 and 4)
module tb_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, sub, out_ready;
  logic [31:0] in1, in2;
  wire         in_ready, out_valid, carry_out;
  wire  [31:0] adder_out;
  wire         ovf, zero;

  logic        v16, rdy16;
  logic [15:0] a16, b16;
  wire         rdy_s1, ov_s1, c_s1, of_s1, z_s1;
  wire  [15:0] sum_s1;
  wire         rdy_s4, ov_s4, c_s4, of_s4, z_s4;
  wire  [15:0] sum_s4;

`ifndef PIPE_ADDER_FLAGS_EN
  assign ovf  = 1'b0;
  assign zero = 1'b0;
  assign of_s1 = 1'b0;
  assign z_s1  = 1'b0;
  assign of_s4 = 1'b0;
  assign z_s4  = 1'b0;
`endif

  pipe_adder #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .adder_out(adder_out), .carry_out(carry_out)
`ifdef PIPE_ADDER_FLAGS_EN
    , .overflow(ovf), .zero(zero)
`endif
  );

  pipe_adder #(.WIDTH(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy_s1),
    .in1(a16), .in2(b16), .sub(1'b0), .out_valid(ov_s1), .out_ready(rdy16),
    .adder_out(sum_s1), .carry_out(c_s1)
`ifdef PIPE_ADDER_FLAGS_EN
    , .overflow(of_s1), .zero(z_s1)
`endif
  );

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy_s4),
    .in1(a16), .in2(b16), .sub(1'b0), .out_valid(ov_s4), .out_ready(rdy16),
    .adder_out(sum_s4), .carry_out(c_s4)
`ifdef PIPE_ADDER_FLAGS_EN
    , .overflow(of_s4), .zero(z_s4)
`endif
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        ovf;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    logic [32:0] r;
    r     = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    e.sum = r[31:0];
    e.c   = s ? (a >= b) : r[32];
    e.z   = (r[31:0] == 32'd0);
    e.ovf = s ? ((a[31] != b[31]) && (r[31] != a[31]))
              : ((a[31] == b[31]) && (r[31] != a[31]));
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          popped++;
          chk("sum", adder_out, e.sum);
          chk("carry", carry_out, e.c);
`ifdef PIPE_ADDER_FLAGS_EN
          chk("overflow", ovf, e.ovf);
          chk("zero", zero, e.z);
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in1, in2, sub));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic ok;
    ok = 1'b0;
    in1 = a; in2 = b; sub = s; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", done, 1'b1);
  endtask

  initial begin
    #300000;
    $fatal(1, "FAIL watchdog timeout");
  end

  initial begin
    int          lat, lat1, lat4, stale;
    logic [31:0] held;
    logic [15:0] s1v, s4v;
    logic        o1, o4, c1, c4;

    rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b1;
    v16 = 1'b0; rdy16 = 1'b1; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_adder_out", adder_out, 32'd0);
    chk("rst_carry_out", carry_out, 1'b0);
    rst_n = 1'b1;

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_out(lat);
    chk("latency_s2", lat, 2);
    chk("wrap_sum", adder_out, 32'h0000_0000);
    chk("wrap_carry", carry_out, 1'b1);
`ifdef PIPE_ADDER_FLAGS_EN
    chk("wrap_zero", zero, 1'b1);
    chk("wrap_ovf", ovf, 1'b0);
`endif
    @(posedge clk);
    #1;
    send(32'h0000_0000, 32'h0000_0001, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b1);
    drain();

    popped = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(i, 3 * i, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = '0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 1'b0);
          if (j == 0) held = adder_out;
          else chk("stall_hold", adder_out, held);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", popped, 16);

    out_ready = 1'b0;
    send(32'd5, 32'd6, 1'b0);
    send(32'd7, 32'd8, 1'b0);
    chk("inflight_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale", stale, 0);
    @(posedge clk);
    #1;

    popped = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("random_count", popped, 24);

    a16 = 16'h7FFF; b16 = 16'h0001; v16 = 1'b1;
    chk("s1_in_ready", rdy_s1, 1'b1);
    chk("s4_in_ready", rdy_s4, 1'b1);
    @(posedge clk);
    #1;
    v16 = 1'b0;
    lat1 = 0; lat4 = 0;
    s1v = '0; s4v = '0; o1 = 1'b0; o4 = 1'b0; c1 = 1'b0; c4 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ov_s1 && lat1 == 0) begin lat1 = i; s1v = sum_s1; o1 = of_s1; c1 = c_s1; end
      if (ov_s4 && lat4 == 0) begin lat4 = i; s4v = sum_s4; o4 = of_s4; c4 = c_s4; end
    end
    chk("s1_latency", lat1, 1);
    chk("s4_latency", lat4, 4);
    chk("s1_sum", s1v, 16'h8000);
    chk("s4_sum", s4v, 16'h8000);
    chk("s1_carry", c1, 1'b0);
    chk("s4_carry", c4, 1'b0);
`ifdef PIPE_ADDER_FLAGS_EN
    chk("s1_ovf", o1, 1'b1);
    chk("s4_ovf", o4, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a positive multiple of STAGES.
REQ-002 Parameter STAGES, default 2: pipeline depth and number of carry chunks; SHALL be in the range 1..8.
REQ-003 Ports SHALL be:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts a beat this cycle.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- adder_out  out  WIDTH  result, modulo 2^WIDTH.
- carry_out  out  1  raw carry out of the MSB.
- overflow  out  1  signed two's-complement overflow; present only with PIPE_ADDER_FLAGS_EN.
- zero  out  1  adder_out == 0; present only with PIPE_ADDER_FLAGS_EN.

Function
REQ-004 A beat SHALL transfer on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-005 Subtraction SHALL be computed as A + ~B + 1, with carry-in 1 and no separate subtractor.
REQ-006 The operation SHALL be split into STAGES chunks of WIDTH/STAGES bits.
- Stage k adds chunk k with the registered carry from stage k-1.
- Upper operand chunks are carried forward in skew registers.
- Completed lower result chunks are carried forward in deskew registers.
REQ-007 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, with no stall.
REQ-008 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-009 stall SHALL be defined as out_valid && !out_ready.
- When stalled, every pipeline register, including the per-stage valid bits, holds its value.
- in_ready is !stall; no combinational path from in_valid to in_ready.
REQ-010 When not stalled, a bubble (in_valid low) SHALL propagate as a cleared valid bit; data registers in bubble stages are don't-care.
REQ-011 Results SHALL leave in strict issue order; no beat is dropped or duplicated under any pattern of in_valid and out_ready.
REQ-012 carry_out SHALL be the carry out of the top chunk; for sub it is 1 when A >= B (unsigned), i.e. not-borrow.
REQ-013 Overflow: for add, set when operand signs are equal and the result sign differs; for sub, set when operand signs differ and the result sign differs from A.
REQ-014 adder_out, carry_out and flags SHALL be registered outputs that remain stable while out_valid && !out_ready.
REQ-015 With STAGES = 1 the block SHALL degenerate to a single registered full-width add with the same handshake.

Reset
REQ-016 While rst_n is low at a clock edge, all stage valid bits, out_valid, adder_out, carry_out and flags SHALL clear to 0.
REQ-017 in_ready SHALL be 1 during and after reset, since out_valid is 0.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight beats; no result for them appears after release.

Configuration
REQ-019 Macro PIPE_ADDER_FLAGS_EN: when defined, the overflow and zero ports and their pipelined logic SHALL exist.
- zero is computed in the final stage from the full result.
- When undefined, the ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-020 A shared package pipe_adder_pkg SHALL hold the default constants PIPE_ADDER_WIDTH = 32 and PIPE_ADDER_STAGES = 2, and an op_e enum (OP_ADD, OP_SUB).
REQ-021 A single sub-module, pipe_adder_chunk, SHALL implement one stage's chunk add: inputs a, b and cin; outputs sum and cout; parameter CW.
REQ-022 pipe_adder SHALL instantiate STAGES copies of pipe_adder_chunk via generate.

Verification
REQ-023 Benches SHALL cover:
- WIDTH 32, STAGES 2, add 0xFFFFFFFF + 0x00000001 -> after 2 cycles adder_out 0x00000000, carry_out 1, zero 1, overflow 0.
- sub 0x00000000 - 0x00000001 -> adder_out 0xFFFFFFFF, carry_out 0; sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, overflow 1.
- Back-to-back stream of 16 beats (i, 3i), out_ready held low for cycles 5-8 -> in_ready low during the stall, all 16 sums 4i in order, none lost.
- rst_n low for 1 cycle with 2 beats in flight -> out_valid 0 next cycle; no stale result emitted after release.
- STAGES 1 and STAGES 4, WIDTH 16, add 0x7FFF + 0x0001 -> 0x8000, overflow 1, latency 1 and 4 respectively.
- Build without PIPE_ADDER_FLAGS_EN -> compiles without the flag ports; sums and carry_out identical to the flagged build under the same random stream.
